audio_recorder: RTL and testbench
=================================

# audio_recorder

Captures microphone samples from the Audio_Controller input FIFO and writes them, quantised to 6 bits, into a 16384 x 6 single-port RAM. It is the write side of the existing ROM/RAM playback path: each stored sample is the top 6 bits of the 32-bit left-channel word, so the playback path can replay the same RAM contents directly as `{sample, 26'b0}`. It sits between Audio_Controller (`audio_in_available`/`read_audio_in` handshake) and the RAM write port, on CLOCK_50.

## Interface
- ADDR_W, 14, RAM address width; capacity is 2^ADDR_W samples.
- SAMPLE_W, 6, stored sample width; the MSBs of the 32-bit audio word.
- DECIM, 1, store every DECIM-th sample read (1..255); every sample is still read so the FIFO drains.

- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high; all state and outputs cleared.
- start  in  1  level sampled each cycle; in IDLE, begins a recording at address 0.
- stop  in  1  ends the recording early.
- audio_in_available  in  1  Audio_Controller has a sample pair ready.
- left_channel_audio_in  in  32  signed left sample.
- right_channel_audio_in  in  32  signed right sample; used only with RECORDER_MONO_MIX_EN.
- read_audio_in  out  1  one-cycle pop strobe to Audio_Controller.
- ram_address  out  ADDR_W  RAM write address.
- ram_data  out  SAMPLE_W  RAM write data.
- ram_wren  out  1  one-cycle RAM write enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a recording ends.
- sample_count  out  ADDR_W+1  samples written in the current or last recording (0..2^ADDR_W).

## Operation
- FSM states are IDLE, CAPTURE, WRITE, HOLD and DONE. All outputs are registered.
- **IDLE:**
  - If start=1 and stop=0: clear ram_address, sample_count and the decimation counter, then go to CAPTURE.
  - If start and stop are both high, stop wins and the FSM stays in IDLE.
- **CAPTURE:**
  - If stop=1: go to DONE.
  - Else if audio_in_available=1: latch the sample word, pulse read_audio_in, and go to WRITE.
- **WRITE:**
  - Decimation counter == DECIM-1 (keep): drive ram_data and pulse ram_wren at the current ram_address, reset the counter, and increment sample_count.
  - Otherwise (skip): increment the decimation counter; no write.
  - Then go to HOLD.
- **HOLD:**
  - Waits one cycle so that audio_in_available can deassert after the pop.
  - ram_address increments here, only after a write.
  - Go to DONE if the write just made was to address 2^ADDR_W-1 (RAM full) or if stop=1. Otherwise return to CAPTURE.
- **DONE:** pulse done, then go to IDLE.
- **Quantisation:** ram_data = left_channel_audio_in[31:32-SAMPLE_W] (truncation, no rounding).
- **Boundaries:**
  - start is ignored while busy.
  - stop arriving in WRITE is acted on in HOLD: the in-flight write completes.
  - ram_address never wraps within a recording. After a full recording it holds 2^ADDR_W-1, and the next start resets it to 0.
  - sample_count holds its value through IDLE until the next start.
  - Asserting reset mid-recording aborts immediately: outputs go to 0, and the RAM keeps any partial data.

## Timing
- Reset values: read_audio_in=0, ram_wren=0, ram_address=0, ram_data=0, busy=0, done=0, sample_count=0. FSM starts in IDLE.
- **Start:** start sampled high at edge k gives busy=1 from cycle k+1.
- **Per sample:** CAPTURE with audio_in_available seen at edge n gives:
  - read_audio_in=1 during cycle n+1;
  - ram_wren=1 during cycle n+2;
  - ram_address incremented in cycle n+3;
  - back in CAPTURE from cycle n+4.
  - The minimum is 4 cycles per sample, far below the 1042-cycle period of 48 kHz audio.
- **End of recording:** done is high for exactly one cycle, and busy drops in the cycle after done.

## Configuration
- Macro: RECORDER_MONO_MIX_EN.
  - Defined: ram_data = bits [32:33-SAMPLE_W] of the 33-bit signed sum left+right, which is the average of both channels.
  - Undefined: left channel only, and right_channel_audio_in is unused.

## Test plan
- **Reset mid-recording:** assert reset during WRITE -> all outputs 0 in the same cycle and FSM in IDLE; the next start records from address 0.
- **Basic capture:** start, then 3 samples with left=32'h7C00_0000, 32'h0400_0000, 32'hFC00_0000 -> writes at addresses 0,1,2 with data 6'h1F, 6'h01, 6'h3F; one read_audio_in per sample; sample_count=3 after stop.
- **Full RAM:** ADDR_W=4, feed 20 samples -> exactly 16 writes (addresses 0..15), done pulses after the write to 15, busy=0, remaining samples not popped.
- **Decimation:** DECIM=3, 9 samples -> 9 read_audio_in pulses, 3 writes (samples 3, 6, 9) at addresses 0..2.
- **Stop/start races:** stop and start together in IDLE -> no recording. Stop during WRITE -> that write completes, done follows two cycles later. start while busy -> ignored.
- **Mono mix (RECORDER_MONO_MIX_EN defined):** left=32'h4000_0000, right=32'h0000_0000 -> ram_data=6'h08. Same stimulus with the macro undefined -> 6'h10.

Source files
------------

// File: rtl/audio_recorder.sv
// audio_recorder: pops samples from the Audio_Controller input FIFO, quantises
// each one to SAMPLE_W bits and writes it into the playback RAM. Every sample is
// popped, and only every DECIM-th popped sample is written.
// Optional build macro: RECORDER_MONO_MIX_EN stores the average of the left and
// right channels instead of the left channel alone.
//
// state   | meaning
// IDLE    | waiting for start
// CAPTURE | waiting for a sample pair, or for stop
// WRITE   | writes the latched sample, or skips it for decimation
// HOLD    | two cycles: advance the address, then choose DONE or CAPTURE
// DONE    | one-cycle done pulse, then back to IDLE
module audio_recorder #(
  parameter int ADDR_W   = 14,
  parameter int SAMPLE_W = 6,
  parameter int DECIM    = 1
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                audio_in_available,
  input  logic [31:0]         left_channel_audio_in,
  input  logic [31:0]         right_channel_audio_in,
  output logic                read_audio_in,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [SAMPLE_W-1:0] ram_data,
  output logic                ram_wren,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     sample_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [7:0]        DECIM_LAST = 8'(DECIM - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX   = {ADDR_W{1'b1}};

  logic [2:0]          state;
  logic [7:0]          decim_cnt;
  logic [SAMPLE_W-1:0] sample_q;
  logic                wrote;
  logic                full;
  logic                hold_wait;
  logic [SAMPLE_W-1:0] quant;
  logic                unused_bits;

`ifdef RECORDER_MONO_MIX_EN
  // The top bits of the 33-bit signed sum are the truncated channel average.
  logic [32:0] mix_sum;
  assign mix_sum     = {left_channel_audio_in[31], left_channel_audio_in} +
                       {right_channel_audio_in[31], right_channel_audio_in};
  assign quant       = mix_sum[32:33-SAMPLE_W];
  assign unused_bits = ^mix_sum[32-SAMPLE_W:0];
`else
  assign quant       = left_channel_audio_in[31:32-SAMPLE_W];
  assign unused_bits = ^{right_channel_audio_in, left_channel_audio_in[31-SAMPLE_W:0]};
`endif

  // Recording FSM; all outputs are registered and the strobes default low.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      decim_cnt     <= '0;
      sample_q      <= '0;
      wrote         <= 1'b0;
      full          <= 1'b0;
      hold_wait     <= 1'b0;
      read_audio_in <= 1'b0;
      ram_address   <= '0;
      ram_data      <= '0;
      ram_wren      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      sample_count  <= '0;
    end else begin
      read_audio_in <= 1'b0;
      ram_wren      <= 1'b0;
      done          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            ram_address  <= '0;
            sample_count <= '0;
            decim_cnt    <= '0;
            busy         <= 1'b1;
            state        <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (stop) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (audio_in_available) begin
            sample_q      <= quant;
            read_audio_in <= 1'b1;
            state         <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (decim_cnt == DECIM_LAST) begin
            ram_data     <= sample_q;
            ram_wren     <= 1'b1;
            decim_cnt    <= '0;
            sample_count <= sample_count + 1'b1;
            wrote        <= 1'b1;
          end else begin
            decim_cnt <= decim_cnt + 8'd1;
            wrote     <= 1'b0;
          end
          hold_wait <= 1'b0;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          // First cycle advances the address; the last address is kept so it
          // never wraps. Second cycle gives the FIFO time to drop available.
          if (!hold_wait) begin
            hold_wait <= 1'b1;
            full      <= wrote && (ram_address == ADDR_MAX);
            if (wrote && (ram_address != ADDR_MAX))
              ram_address <= ram_address + 1'b1;
          end else if (full || stop) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_CAPTURE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_recorder.sv
// Directed bench for audio_recorder: one full-size instance for timing and
// race checks, a 16-entry instance for the RAM-full case, and a 16-entry
// instance with DECIM=3 for decimation.
module tb_audio_recorder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] left, right;
  logic        start_s [3];
  logic        stop_s  [3];
  logic        avail_s [3];
  logic        rd      [3];
  logic        wr      [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic [5:0]  d       [3];
  logic [13:0] a0;
  logic [3:0]  a1, a2;
  logic [14:0] cnt0;
  logic [4:0]  cnt1, cnt2;

  int checks = 0;
  int failures = 0;
  int rd_cnt [3] = '{0, 0, 0};
  int wr_cnt [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};

`ifdef RECORDER_MONO_MIX_EN
  localparam logic [5:0] EXP_MIX = 6'h08;
`else
  localparam logic [5:0] EXP_MIX = 6'h10;
`endif

  always #5 clk = ~clk;

  audio_recorder #(.ADDR_W(14), .SAMPLE_W(6), .DECIM(1)) u_main (
    .CLOCK_50(clk), .reset(rst), .start(start_s[0]), .stop(stop_s[0]),
    .audio_in_available(avail_s[0]), .left_channel_audio_in(left),
    .right_channel_audio_in(right), .read_audio_in(rd[0]), .ram_address(a0),
    .ram_data(d[0]), .ram_wren(wr[0]), .busy(busy_s[0]), .done(done_s[0]),
    .sample_count(cnt0));

  audio_recorder #(.ADDR_W(4), .SAMPLE_W(6), .DECIM(1)) u_small (
    .CLOCK_50(clk), .reset(rst), .start(start_s[1]), .stop(stop_s[1]),
    .audio_in_available(avail_s[1]), .left_channel_audio_in(left),
    .right_channel_audio_in(right), .read_audio_in(rd[1]), .ram_address(a1),
    .ram_data(d[1]), .ram_wren(wr[1]), .busy(busy_s[1]), .done(done_s[1]),
    .sample_count(cnt1));

  audio_recorder #(.ADDR_W(4), .SAMPLE_W(6), .DECIM(3)) u_dec (
    .CLOCK_50(clk), .reset(rst), .start(start_s[2]), .stop(stop_s[2]),
    .audio_in_available(avail_s[2]), .left_channel_audio_in(left),
    .right_channel_audio_in(right), .read_audio_in(rd[2]), .ram_address(a2),
    .ram_data(d[2]), .ram_wren(wr[2]), .busy(busy_s[2]), .done(done_s[2]),
    .sample_count(cnt2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters, plus write checks for the small instances: the n-th write
  // must land at address n carrying the value chosen by the feeding sequence.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (rd[k]) rd_cnt[k]++;
        if (done_s[k]) done_cnt[k]++;
      end
      if (wr[0]) wr_cnt[0]++;
      if (wr[1]) begin
        check("full_addr", 32'(a1), 32'(wr_cnt[1]));
        check("full_data", 32'(d[1]), 32'(6'(wr_cnt[1] + 1)));
        wr_cnt[1]++;
      end
      if (wr[2]) begin
        check("decim_addr", 32'(a2), 32'(wr_cnt[2]));
        check("decim_data", 32'(d[2]), 32'(3 * (wr_cnt[2] + 1)));
        wr_cnt[2]++;
      end
    end
  end

  // Present one sample pair to instance k and hold it until popped.
  task automatic feed(input int k, input logic [31:0] l);
    bit got;
    got = 1'b0;
    left = l;
    right = l;
    avail_s[k] = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (rd[k]) got = 1'b1;
    end
    avail_s[k] = 1'b0;
    check("pop_seen", 32'(got), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // Cycle-exact single sample on the main instance, entered in CAPTURE.
  task automatic timed_sample(input logic [31:0] l, input logic [31:0] r,
                              input logic [5:0] ed, input logic [13:0] ea);
    left = l;
    right = r;
    avail_s[0] = 1'b1;
    @(negedge clk);
    check("t_read", 32'(rd[0]), 32'd1);
    check("t_wren_early", 32'(wr[0]), 32'd0);
    avail_s[0] = 1'b0;
    @(negedge clk);
    check("t_read_once", 32'(rd[0]), 32'd0);
    check("t_wren", 32'(wr[0]), 32'd1);
    check("t_addr", 32'(a0), 32'(ea));
    check("t_data", 32'(d[0]), 32'(ed));
    @(negedge clk);
    check("t_wren_once", 32'(wr[0]), 32'd0);
    check("t_addr_inc", 32'(a0), 32'(ea + 14'd1));
    @(negedge clk);
  endtask

  task automatic start_main;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    check("start_busy", 32'(busy_s[0]), 32'd1);
  endtask

  task automatic stop_main(input logic [14:0] exp_cnt);
    stop_s[0] = 1'b1;
    @(negedge clk);
    stop_s[0] = 1'b0;
    check("stop_done", 32'(done_s[0]), 32'd1);
    @(negedge clk);
    check("stop_done_once", 32'(done_s[0]), 32'd0);
    check("stop_busy", 32'(busy_s[0]), 32'd0);
    check("stop_count", 32'(cnt0), 32'(exp_cnt));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] vals [3];
    logic [5:0]  exps [3];
    int          r0, d0;
    vals = '{32'h7C00_0000, 32'h0400_0000, 32'hFC00_0000};
    exps = '{6'h1F, 6'h01, 6'h3F};

    rst = 1'b1;
    left = '0;
    right = '0;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; stop_s[k] = 1'b0; avail_s[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_read", 32'(rd[0]), 32'd0);
    check("rst_wren", 32'(wr[0]), 32'd0);
    check("rst_addr", 32'(a0), 32'd0);
    check("rst_data", 32'(d[0]), 32'd0);
    check("rst_busy", 32'(busy_s[0]), 32'd0);
    check("rst_done", 32'(done_s[0]), 32'd0);
    check("rst_count", 32'(cnt0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset asserted while the FSM is in WRITE.
    start_main();
    left = 32'h7C00_0000;
    right = 32'h7C00_0000;
    avail_s[0] = 1'b1;
    @(negedge clk);
    check("mid_read_before", 32'(rd[0]), 32'd1);
    avail_s[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_read", 32'(rd[0]), 32'd0);
    check("mid_busy", 32'(busy_s[0]), 32'd0);
    check("mid_wren", 32'(wr[0]), 32'd0);
    check("mid_count", 32'(cnt0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_idle", 32'(busy_s[0]), 32'd0);

    // Basic capture from address 0.
    r0 = rd_cnt[0];
    start_main();
    for (int i = 0; i < 3; i++)
      timed_sample(vals[i], vals[i], exps[i], 14'(i));
    stop_main(15'd3);
    check("basic_pops", 32'(rd_cnt[0] - r0), 32'd3);

    // Stop and start together in IDLE: no recording.
    d0 = done_cnt[0];
    start_s[0] = 1'b1;
    stop_s[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("race_idle_busy", 32'(busy_s[0]), 32'd0);
    start_s[0] = 1'b0;
    stop_s[0] = 1'b0;
    @(negedge clk);
    check("race_idle_done", 32'(done_cnt[0] - d0), 32'd0);
    check("race_idle_count", 32'(cnt0), 32'd3);

    // Stop (and a stray start) during WRITE: write completes, done two cycles on.
    start_main();
    left = 32'h0400_0000;
    right = 32'h0400_0000;
    avail_s[0] = 1'b1;
    @(negedge clk);
    check("sw_read", 32'(rd[0]), 32'd1);
    avail_s[0] = 1'b0;
    stop_s[0] = 1'b1;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    check("sw_wren", 32'(wr[0]), 32'd1);
    check("sw_addr", 32'(a0), 32'd0);
    check("sw_data", 32'(d[0]), 32'h01);
    check("sw_done_early", 32'(done_s[0]), 32'd0);
    @(negedge clk);
    check("sw_done_early2", 32'(done_s[0]), 32'd0);
    @(negedge clk);
    stop_s[0] = 1'b0;
    check("sw_done", 32'(done_s[0]), 32'd1);
    check("sw_busy_in_done", 32'(busy_s[0]), 32'd1);
    @(negedge clk);
    check("sw_busy", 32'(busy_s[0]), 32'd0);
    check("sw_count", 32'(cnt0), 32'd1);
    repeat (2) @(negedge clk);
    check("sw_stay_idle", 32'(busy_s[0]), 32'd0);

    // Quantisation of a left-only sample (mono mix halves it).
    start_main();
    timed_sample(32'h4000_0000, 32'h0000_0000, EXP_MIX, 14'd0);
    stop_main(15'd1);

    // RAM full on the 16-entry instance.
    start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    for (int i = 0; i < 16; i++)
      feed(1, {6'(i + 1), 26'h0});
    check("full_writes", 32'(wr_cnt[1]), 32'd16);
    check("full_done", 32'(done_cnt[1]), 32'd1);
    check("full_busy", 32'(busy_s[1]), 32'd0);
    check("full_addr_hold", 32'(a1), 32'd15);
    check("full_count", 32'(cnt1), 32'd16);
    left = 32'h4400_0000;
    right = 32'h4400_0000;
    avail_s[1] = 1'b1;
    repeat (20) @(negedge clk);
    avail_s[1] = 1'b0;
    check("full_no_pop", 32'(rd_cnt[1]), 32'd16);
    check("full_no_write", 32'(wr_cnt[1]), 32'd16);

    // Decimation by 3 over 9 samples.
    start_s[2] = 1'b1;
    @(negedge clk);
    start_s[2] = 1'b0;
    for (int i = 1; i <= 9; i++)
      feed(2, {6'(i), 26'h0});
    stop_s[2] = 1'b1;
    @(negedge clk);
    stop_s[2] = 1'b0;
    repeat (2) @(negedge clk);
    check("decim_pops", 32'(rd_cnt[2]), 32'd9);
    check("decim_writes", 32'(wr_cnt[2]), 32'd3);
    check("decim_count", 32'(cnt2), 32'd3);
    check("decim_busy", 32'(busy_s[2]), 32'd0);
    check("decim_done", 32'(done_cnt[2]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
